// File: rtl/counter_pkg.sv
// Shared definitions for the event counter family: mode encodings, common
// terminal-count constants, the derived run state and the per-cycle command
// decode used by the counter datapath.
package counter_pkg;

  // Mode input encodings.
  localparam logic MODE_RELOAD  = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Common terminal indices (N-1 for N events).
  localparam logic [6:0] TC_100  = 7'd99;
  localparam logic [9:0] TC_1000 = 10'd999;

  // Run state is not stored; it is implied by the sticky done flag and mode.
  typedef enum logic {
    ST_COUNTING = 1'b0,
    ST_HALTED   = 1'b1
  } run_state_e;

  // What the datapath does on the coming clock edge, already prioritised.
  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_CLEAR = 2'd1,
    CMD_LOAD  = 2'd2,
    CMD_EVENT = 2'd3
  } cmd_e;

  // Derive the run state from mode and done.
  function automatic run_state_e run_state(input logic mode, input logic done);
    if ((mode == MODE_ONESHOT) && done) begin
      return ST_HALTED;
    end else begin
      return ST_COUNTING;
    end
  endfunction

  // Resolve clear > load > event into a single command.
  function automatic cmd_e decode_cmd(input logic clr, input logic load, input logic ev);
    if (clr) begin
      return CMD_CLEAR;
    end else if (load) begin
      return CMD_LOAD;
    end else if (ev) begin
      return CMD_EVENT;
    end else begin
      return CMD_IDLE;
    end
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the input once and flags the cycle where
// it is high while its registered copy is still low. The register follows
// the input every cycle; only the synchronous reset overrides it.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q_r;

  // Delay the input by one clock; cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q_r <= 1'b0;
    end else begin
      d_q_r <= d;
    end
  end

  assign pulse = d & ~d_q_r;

endmodule

// File: rtl/event_timeout_counter.sv
// Counts qualified increment events and emits a one-cycle timeout pulse on
// the event that reaches the terminal index. Supports auto-reload and
// one-shot operation, runtime terminal-count loading, synchronous clear and
// optional rising-edge qualification of the increment input.
module event_timeout_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned DEFAULT_TC = 99,
  parameter int unsigned EDGE       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             increment,
  output logic [WIDTH-1:0] count,
  output logic             timeout,
  output logic             done,
  output logic             running
);

  localparam logic [WIDTH-1:0] TC_RST = WIDTH'(DEFAULT_TC);
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] tc_r;
  logic             done_r;
  logic             timeout_r;

  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] tc_nxt_s;
  logic             done_nxt_s;
  logic             timeout_nxt_s;

  logic             qual_s;
  logic             ev_s;
  logic             at_tc_s;
  run_state_e       state_s;
  cmd_e             cmd_s;

  // Edge qualification is combinational against the registered input so an
  // edge is counted in the same cycle it appears; level mode passes through.
  if (EDGE != 0) begin : g_edge
    rise_detect u_rise (
      .clk   (clk),
      .rst   (rst),
      .d     (increment),
      .pulse (qual_s)
    );
  end else begin : g_level
    assign qual_s = increment;
  end

  assign state_s = run_state(mode, done_r);
  assign ev_s    = qual_s & en & (state_s == ST_COUNTING);
  assign at_tc_s = (count_r == tc_r);
  assign cmd_s   = decode_cmd(clr, load, ev_s);

  // Next-state logic: apply the prioritised command; timeout defaults low.
  always_comb begin
    count_nxt_s   = count_r;
    tc_nxt_s      = tc_r;
    done_nxt_s    = done_r;
    timeout_nxt_s = 1'b0;
    case (cmd_s)
      CMD_CLEAR: begin
        count_nxt_s = '0;
        done_nxt_s  = 1'b0;
      end
      CMD_LOAD: begin
        tc_nxt_s    = load_val;
        count_nxt_s = '0;
        done_nxt_s  = 1'b0;
      end
      CMD_EVENT: begin
        if (at_tc_s) begin
          count_nxt_s   = '0;
          timeout_nxt_s = 1'b1;
          done_nxt_s    = 1'b1;
        end else begin
          count_nxt_s   = count_r + ONE_W;
        end
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r   <= '0;
      tc_r      <= TC_RST;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      tc_r      <= tc_nxt_s;
      done_r    <= done_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  assign count   = count_r;
  assign timeout = timeout_r;
  assign done    = done_r;
  // Running reflects the current inputs, so a mode change shows immediately.
  assign running = en & ~(mode & done_r);

endmodule

// File: tb/tb_event_timeout_counter.sv
// Bench for event_timeout_counter: a level-mode and an edge-mode instance
// share all inputs. Each cycle a reference model predicts the next outputs
// of both, the prediction is queued, and it is popped and compared after
// the clock edge. Directed checks pin the headline numbers of each scenario.
module tb_event_timeout_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic       mode;
  logic       load;
  logic [6:0] load_val;
  logic       increment;

  logic [6:0] count0, count1;
  logic       timeout0, timeout1;
  logic       done0, done1;
  logic       running0, running1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [6:0] c0;
    logic [6:0] c1;
    logic       t0;
    logic       t1;
    logic       d0;
    logic       d1;
  } exp_t;

  exp_t sb_q[$];

  logic [6:0] m_count [0:1];
  logic [6:0] m_tc    [0:1];
  logic       m_done  [0:1];
  logic       m_to    [0:1];
  logic       m_incq  [0:1];
  logic       model_ok = 1'b0;

  int to_cnt0 = 0;
  int to_cnt1 = 0;
  logic cur_en   = 1'b1;
  logic cur_mode = 1'b0;

  event_timeout_counter #(.WIDTH(7), .DEFAULT_TC(99), .EDGE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .load(load),
    .load_val(load_val), .increment(increment), .count(count0),
    .timeout(timeout0), .done(done0), .running(running0)
  );

  event_timeout_counter #(.WIDTH(7), .DEFAULT_TC(99), .EDGE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .load(load),
    .load_val(load_val), .increment(increment), .count(count1),
    .timeout(timeout1), .done(done1), .running(running1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, predict, sample #1 after posedge.
  task automatic cycle(input logic rst_v, input logic en_v, input logic clr_v,
                       input logic mode_v, input logic load_v,
                       input logic [6:0] lv_v, input logic inc_v);
    exp_t e_push;
    exp_t e_pop;
    rst = rst_v; en = en_v; clr = clr_v; mode = mode_v;
    load = load_v; load_val = lv_v; increment = inc_v;
    #1;
    if (model_ok) begin
      chk("running0", 32'(running0), 32'(en_v & ~(mode_v & m_done[0])));
      chk("running1", 32'(running1), 32'(en_v & ~(mode_v & m_done[1])));
    end
    for (int e = 0; e < 2; e++) begin
      logic q;
      logic ev;
      q  = (e == 1) ? (inc_v & ~m_incq[e]) : inc_v;
      ev = q & en_v & ~(mode_v & m_done[e]);
      m_to[e] = 1'b0;
      if (!rst_v) begin
        m_count[e] = 7'd0; m_tc[e] = 7'd99; m_done[e] = 1'b0;
      end else if (clr_v) begin
        m_count[e] = 7'd0; m_done[e] = 1'b0;
      end else if (load_v) begin
        m_tc[e] = lv_v; m_count[e] = 7'd0; m_done[e] = 1'b0;
      end else if (ev) begin
        if (m_count[e] == m_tc[e]) begin
          m_count[e] = 7'd0; m_to[e] = 1'b1; m_done[e] = 1'b1;
        end else begin
          m_count[e] = m_count[e] + 7'd1;
        end
      end
      m_incq[e] = rst_v ? inc_v : 1'b0;
    end
    model_ok = 1'b1;
    e_push = '{c0: m_count[0], c1: m_count[1], t0: m_to[0], t1: m_to[1],
               d0: m_done[0], d1: m_done[1]};
    sb_q.push_back(e_push);
    @(posedge clk);
    #1;
    e_pop = sb_q.pop_front();
    chk("count0", 32'(count0), 32'(e_pop.c0));
    chk("count1", 32'(count1), 32'(e_pop.c1));
    chk("timeout0", 32'(timeout0), 32'(e_pop.t0));
    chk("timeout1", 32'(timeout1), 32'(e_pop.t1));
    chk("done0", 32'(done0), 32'(e_pop.d0));
    chk("done1", 32'(done1), 32'(e_pop.d1));
    to_cnt0 += 32'(timeout0);
    to_cnt1 += 32'(timeout1);
    @(negedge clk);
  endtask

  task automatic cyc(input logic clr_v, input logic load_v,
                     input logic [6:0] lv_v, input logic inc_v);
    cycle(1'b1, cur_en, clr_v, cur_mode, load_v, lv_v, inc_v);
  endtask

  task automatic run(input int n, input logic inc_v);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 7'd0, inc_v);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; mode = 1'b0;
    load = 1'b0; load_val = 7'd0; increment = 1'b0;
    @(negedge clk);

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    chk("rst_count", 32'(count0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_timeout", 32'(timeout0), 0);

    // 1: default tc, level mode, increment held high 250 cycles
    cur_en = 1'b1; cur_mode = 1'b0;
    to_cnt0 = 0; to_cnt1 = 0;
    run(250, 1'b1);
    chk("t1_timeouts", to_cnt0, 2);
    chk("t1_count", 32'(count0), 50);
    chk("t1_done", 32'(done0), 1);
    chk("t1_edge_count", 32'(count1), 1);

    // 2: one-shot, tc=2, five increments then clear and resume
    cur_mode = 1'b1;
    cyc(1'b0, 1'b1, 7'd2, 1'b0);
    to_cnt0 = 0;
    run(5, 1'b1);
    chk("t2_timeouts", to_cnt0, 1);
    chk("t2_count", 32'(count0), 0);
    chk("t2_done", 32'(done0), 1);
    chk("t2_running", 32'(running0), 0);
    cyc(1'b1, 1'b0, 7'd0, 1'b0);
    chk("t2_clr_done", 32'(done0), 0);
    run(2, 1'b1);
    chk("t2_resume", 32'(count0), 2);

    // 3: edge mode, tc=3, held high then toggled
    cur_mode = 1'b0;
    cyc(1'b0, 1'b1, 7'd3, 1'b0);
    to_cnt1 = 0;
    run(10, 1'b1);
    chk("t3_hold_count", 32'(count1), 1);
    for (int i = 0; i < 3; i++) begin
      run(1, 1'b0);
      run(1, 1'b1);
    end
    chk("t3_timeouts", to_cnt1, 1);
    chk("t3_count", 32'(count1), 0);
    chk("t3_done", 32'(done1), 1);
    run(1, 1'b0);
    cur_en = 1'b0;
    run(1, 1'b1);
    cur_en = 1'b1;
    run(2, 1'b1);
    chk("t3_lost_edge", 32'(count1), 0);

    // 4: clear or load coinciding with the terminal event
    cyc(1'b0, 1'b1, 7'd3, 1'b0);
    to_cnt0 = 0;
    run(3, 1'b1);
    chk("t4_at_tc", 32'(count0), 3);
    cyc(1'b1, 1'b0, 7'd0, 1'b1);
    chk("t4_clr_count", 32'(count0), 0);
    chk("t4_clr_timeout", 32'(timeout0), 0);
    run(3, 1'b1);
    cyc(1'b0, 1'b1, 7'd5, 1'b1);
    chk("t4_load_count", 32'(count0), 0);
    chk("t4_load_timeout", 32'(timeout0), 0);
    run(5, 1'b1);
    chk("t4_new_tc_count", 32'(count0), 5);
    chk("t4_no_timeout", to_cnt0, 0);
    run(1, 1'b1);
    chk("t4_timeout", 32'(timeout0), 1);
    chk("t4_wrap", 32'(count0), 0);

    // 5: tc=0, back-to-back timeouts, then one-shot and mode release
    cyc(1'b0, 1'b1, 7'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run(1, 1'b1);
      chk("t5_consecutive", 32'(timeout0), 1);
    end
    cur_mode = 1'b1;
    cyc(1'b1, 1'b0, 7'd0, 1'b0);
    to_cnt0 = 0;
    run(4, 1'b1);
    chk("t5_oneshot_timeouts", to_cnt0, 1);
    chk("t5_halted_running", 32'(running0), 0);
    cur_mode = 1'b0;
    run(2, 1'b1);
    chk("t5_resume_timeouts", to_cnt0, 3);
    chk("t5_done_sticky", 32'(done0), 1);

    // 6: reset mid-count restores the default terminal count
    cyc(1'b0, 1'b1, 7'd10, 1'b0);
    run(11, 1'b1);
    run(5, 1'b1);
    chk("t6_pre_count", 32'(count0), 5);
    chk("t6_pre_done", 32'(done0), 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    chk("t6_rst_count", 32'(count0), 0);
    chk("t6_rst_done", 32'(done0), 0);
    chk("t6_rst_timeout", 32'(timeout0), 0);
    to_cnt0 = 0;
    run(99, 1'b1);
    chk("t6_count99", 32'(count0), 99);
    chk("t6_no_timeout", to_cnt0, 0);
    run(1, 1'b1);
    chk("t6_timeout100", to_cnt0, 1);
    chk("t6_wrap", 32'(count0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
